// File: rtl/pp_reg_chain.sv
// ============================================================================
// pp_reg_chain : valid-qualified pipeline register chain with stall/flush
//                handling and a saturating hazard-cycle counter.
// Revision 1.0
// ============================================================================
`default_nettype none

module pp_reg_chain #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 3,
  parameter int STALL_POS   = 0,
  parameter bit ZERO_BUBBLE = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  input  logic                       stall,
  input  logic [DEPTH-1:0]           flush,
  input  logic                       cnt_clr,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           hazard_cnt
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DEPTH-1:0] w_src_valid;
  logic [WIDTH-1:0] w_src_data [DEPTH];
  logic             w_hazard;
  logic [OCC_W-1:0] w_occ;

  // Source of each stage when it advances: the input port for stage 0,
  // otherwise the preceding stage.
  assign w_src_valid = {valid_q[DEPTH-2:0], in_valid};

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_src
      if (g == 0) begin : g_head
        assign w_src_data[g] = in_data;
      end else begin : g_link
        assign w_src_data[g] = data_q[g-1];
      end
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = w_src_valid[i];
      data_d[i]  = w_src_data[i];
      if (flush[i] || (stall && (i == STALL_POS + 1))) begin
        valid_d[i] = 1'b0;
        data_d[i]  = ZERO_BUBBLE ? '0 : data_q[i];
      end else if (stall && (i <= STALL_POS)) begin
        valid_d[i] = valid_q[i];
        data_d[i]  = data_q[i];
      end
    end
  end

  assign w_hazard = stall | (|flush);

  // Clear takes precedence over the increment; saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (w_hazard && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + OCC_W'(valid_q[i]);
    end
  end

  assign out_data   = data_q[DEPTH-1];
  assign out_valid  = valid_q[DEPTH-1];
  assign occupancy  = w_occ;
  assign hazard_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pp_reg_chain.sv
// Testbench for pp_reg_chain (WIDTH=8, DEPTH=3, STALL_POS=0, ZERO_BUBBLE=1, CNT_W=4).
`default_nettype none

module tb_pp_reg_chain;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int SP = 0;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         stall;
  logic [D-1:0] flush;
  logic         cnt_clr;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic [1:0]   occupancy;
  logic [CW-1:0] hazard_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: per-stage contents and the hazard count as a plain integer.
  bit           mv [D];
  logic [W-1:0] md [D];
  int           mcnt;

  pp_reg_chain #(
    .WIDTH(W), .DEPTH(D), .STALL_POS(SP), .ZERO_BUBBLE(1'b1), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .stall(stall), .flush(flush), .cnt_clr(cnt_clr), .out_data(out_data),
    .out_valid(out_valid), .occupancy(occupancy), .hazard_cnt(hazard_cnt)
  );

  always #5 clock = ~clock;

  function automatic int model_occ();
    int n = 0;
    for (int i = 0; i < D; i++) n += int'(mv[i]);
    return n;
  endfunction

  // Advance one clock edge, updating the model from the inputs applied at it.
  task automatic tick();
    @(posedge clock);
    if (!reset) begin
      for (int i = 0; i < D; i++) begin mv[i] = 0; md[i] = '0; end
      mcnt = 0;
    end else begin
      for (int i = D - 1; i >= 0; i--) begin
        if (flush[i] || (stall && i == SP + 1)) begin
          mv[i] = 0; md[i] = '0;
        end else if (stall && i <= SP) begin
          // held
        end else if (i == 0) begin
          mv[0] = in_valid; md[0] = in_data;
        end else begin
          mv[i] = mv[i-1]; md[i] = md[i-1];
        end
      end
      if (cnt_clr) mcnt = 0;
      else if (stall || flush != '0) mcnt = (mcnt + 1 > CMAX) ? CMAX : mcnt + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_data = 8'hAA; stall = 0; flush = '0; cnt_clr = 0;
    tick(); tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b exp 0", out_valid); else n_pass++;
    n_total++; if (out_data !== 8'h00) $display("FAIL reset_out_data got %h exp 00", out_data); else n_pass++;
    n_total++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy got %0d exp 0", occupancy); else n_pass++;
    n_total++; if (hazard_cnt !== 4'd0) $display("FAIL reset_hazard_cnt got %0d exp 0", hazard_cnt); else n_pass++;
    reset = 1'b1; in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_total++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || hazard_cnt !== 4'd0)
        $display("FAIL post_reset_idle edge %0d got v=%0b occ=%0d cnt=%0d exp 0/0/0", k, out_valid, occupancy, hazard_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_streaming();
    for (int k = 1; k <= 6; k++) begin
      in_valid = (k <= 4); in_data = 8'(k);
      tick();
      n_total++;
      if (k >= 3) begin
        if (out_valid !== 1'b1 || out_data !== 8'(k - 2))
          $display("FAIL stream_out edge %0d got v=%0b d=%h exp v=1 d=%h", k, out_valid, out_data, 8'(k - 2));
        else n_pass++;
      end else begin
        if (out_valid !== 1'b0) $display("FAIL stream_fill edge %0d got v=%0b exp 0", k, out_valid);
        else n_pass++;
      end
      if (k == 3 || k == 4) begin
        n_total++; if (occupancy !== 2'd3) $display("FAIL stream_occupancy edge %0d got %0d exp 3", k, occupancy); else n_pass++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    in_valid = 1'b0;
    tick(); tick(); tick();
    in_valid = 1'b1; in_data = 8'h05; cnt_clr = 1'b1;
    tick();
    in_valid = 1'b0; in_data = 8'hEE; cnt_clr = 1'b0; stall = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      n_total++; if (out_valid !== 1'b0 || occupancy !== 2'd1 || hazard_cnt !== 4'(k))
        $display("FAIL stall_hold edge %0d got v=%0b occ=%0d cnt=%0d exp 0/1/%0d", k, out_valid, occupancy, hazard_cnt, k);
      else n_pass++;
    end
    stall = 1'b0;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL stall_release1 got v=%0b exp 0", out_valid); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b1 || out_data !== 8'h05 || hazard_cnt !== 4'd2)
      $display("FAIL stall_emerge got v=%0b d=%h cnt=%0d exp 1/05/2", out_valid, out_data, hazard_cnt);
    else n_pass++;
  endtask

  task automatic test_flush_vs_stall();
    cnt_clr = 1'b1; in_valid = 1'b1; in_data = 8'h3C;
    tick();
    n_total++; if (occupancy !== 2'd1 || hazard_cnt !== 4'd0)
      $display("FAIL fvs_setup got occ=%0d cnt=%0d exp 1/0", occupancy, hazard_cnt);
    else n_pass++;
    cnt_clr = 1'b0; in_valid = 1'b0; stall = 1'b1; flush = 3'b001;
    tick();
    n_total++; if (occupancy !== 2'd0 || hazard_cnt !== 4'd1)
      $display("FAIL fvs_flush_wins got occ=%0d cnt=%0d exp 0/1", occupancy, hazard_cnt);
    else n_pass++;
    stall = 1'b0; flush = '0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_total++; if (out_valid !== 1'b0) $display("FAIL fvs_no_emerge edge %0d got v=%0b exp 0", k, out_valid); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    int start;
    start = int'(hazard_cnt === 4'd1) ? 1 : 1;
    stall = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      int exp_c;
      tick();
      exp_c = (start + k > CMAX) ? CMAX : start + k;
      n_total++; if (hazard_cnt !== 4'(exp_c))
        $display("FAIL sat_count edge %0d got %0d exp %0d", k, hazard_cnt, exp_c);
      else n_pass++;
    end
    cnt_clr = 1'b1;
    tick();
    n_total++; if (hazard_cnt !== 4'd0) $display("FAIL sat_clear_wins got %0d exp 0", hazard_cnt); else n_pass++;
    cnt_clr = 1'b0;
    tick();
    n_total++; if (hazard_cnt !== 4'd1) $display("FAIL sat_after_clear got %0d exp 1", hazard_cnt); else n_pass++;
    stall = 1'b0;
  endtask

  task automatic test_midflight_reset();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'(8'hA1 + k);
      tick();
    end
    n_total++; if (occupancy !== 2'd3) $display("FAIL mid_fill got occ=%0d exp 3", occupancy); else n_pass++;
    stall = 1'b1; flush = 3'b100; reset = 1'b0;
    tick();
    n_total++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== 8'h00 || hazard_cnt !== 4'd0)
      $display("FAIL mid_reset got occ=%0d v=%0b d=%h cnt=%0d exp 0/0/00/0", occupancy, out_valid, out_data, hazard_cnt);
    else n_pass++;
    reset = 1'b1; stall = 1'b0; flush = '0; in_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      reset    = ($urandom_range(0, 59) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 6) == 0) ? D'($urandom) : '0;
      cnt_clr  = ($urandom_range(0, 40) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      in_data  = W'($urandom);
      tick();
      n_total++; if (out_valid !== mv[D-1] || out_data !== md[D-1])
        $display("FAIL rand_out cyc %0d got v=%0b d=%h exp v=%0b d=%h", k, out_valid, out_data, mv[D-1], md[D-1]);
      else n_pass++;
      n_total++; if (occupancy !== 2'(model_occ()))
        $display("FAIL rand_occupancy cyc %0d got %0d exp %0d", k, occupancy, model_occ());
      else n_pass++;
      n_total++; if (hazard_cnt !== 4'(mcnt))
        $display("FAIL rand_hazard_cnt cyc %0d got %0d exp %0d", k, hazard_cnt, mcnt);
      else n_pass++;
    end
    reset = 1'b1; stall = 1'b0; flush = '0; cnt_clr = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < D; i++) begin mv[i] = 0; md[i] = '0; end
    mcnt = 0;
    test_reset();
    test_streaming();
    test_stall();
    test_flush_vs_stall();
    test_saturation();
    test_midflight_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
